// File: rtl/ad_ram_burst_writer.sv
// rtl/ad_ram_burst_writer.sv - FIFO-to-RAM burst writer, circular region; RAMWR_ONESHOT_EN stops after one region pass
module ad_ram_burst_writer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 22,
    parameter int BURST_LEN  = 8,
    parameter int BASE_ADDR  = 0,
    parameter int REGION_LEN = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              fifo_rdreq,
    output logic              ram_wr_req,
    output logic [ADDR_W-1:0] ram_wr_addr,
    input  logic              ram_wr_ack,
    input  logic              ram_data_req,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              busy,
    output logic              wrap_pulse,
    output logic [15:0]       burst_cnt
);

    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam int IDX_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0]  BL_C   = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] END_A  = ADDR_W'(BASE_ADDR + REGION_LEN);
    localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_REQ,
        S_BURST,
        S_ADV
`ifdef RAMWR_ONESHOT_EN
        , S_DONE
`endif
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  rd_issued;
    logic [CNT_W-1:0]  wr_idx;
    logic [CNT_W-1:0]  out_idx;
    logic              rd_d1;
    logic [DATA_W-1:0] sample_buf [BURST_LEN];
    logic [ADDR_W-1:0] next_addr;
    logic              addr_wraps;

    assign next_addr  = ram_wr_addr + STEP_A;
    assign addr_wraps = (next_addr == END_A);

    // Word presented to the controller; zero outside a burst so the bus idles clean
    assign ram_wr_data = (state == S_BURST) ? sample_buf[out_idx[IDX_W-1:0]] : '0;

    // Next-state and control outputs, all decoded from registered state
    always_comb begin
        state_n    = state;
        fifo_rdreq = 1'b0;
        ram_wr_req = 1'b0;
        busy       = 1'b1;
        wrap_pulse = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (enable) state_n = S_FILL;
            end
            S_FILL: begin
                fifo_rdreq = !fifo_empty && (rd_issued < BL_C);
                if (wr_idx == BL_C) state_n = S_REQ;
            end
            S_REQ: begin
                ram_wr_req = 1'b1;
                if (ram_wr_ack) state_n = S_BURST;
            end
            S_BURST: begin
                if (ram_data_req && out_idx == LAST_C) state_n = S_ADV;
            end
            S_ADV: begin
                wrap_pulse = addr_wraps;
                state_n    = enable ? S_FILL : S_IDLE;
`ifdef RAMWR_ONESHOT_EN
                if (addr_wraps) state_n = S_DONE;
`endif
            end
`ifdef RAMWR_ONESHOT_EN
            S_DONE: begin
                busy = 1'b0;
                if (!enable) state_n = S_IDLE;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    // State register, counters, address and burst counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            rd_issued   <= '0;
            wr_idx      <= '0;
            out_idx     <= '0;
            rd_d1       <= 1'b0;
            ram_wr_addr <= BASE_A;
            burst_cnt   <= 16'd0;
        end else begin
            state <= state_n;
            rd_d1 <= fifo_rdreq;
            if (state_n == S_FILL && state != S_FILL) begin
                rd_issued <= '0;
                wr_idx    <= '0;
            end else if (state == S_FILL) begin
                if (fifo_rdreq) rd_issued <= rd_issued + 1'b1;
                if (rd_d1)      wr_idx    <= wr_idx + 1'b1;
            end
            if (state == S_REQ && ram_wr_ack) out_idx <= '0;
            if (state == S_BURST && ram_data_req) out_idx <= out_idx + 1'b1;
            if (state == S_ADV) begin
                burst_cnt   <= burst_cnt + 16'd1;
                ram_wr_addr <= addr_wraps ? BASE_A : next_addr;
            end
        end
    end

    // Sample capture one cycle after each read request (normal-mode FIFO latency)
    always_ff @(posedge clk) begin
        if (rd_d1 && state == S_FILL) sample_buf[wr_idx[IDX_W-1:0]] <= fifo_q;
    end

endmodule

// File: tb/tb_ad_ram_burst_writer.sv
// tb/tb_ad_ram_burst_writer.sv - randomized bench with FIFO/controller models and a transaction-level scoreboard
module tb_ad_ram_burst_writer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 22;
    localparam int BL     = 8;
    localparam int BASE   = 0;
    localparam int REGION = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_q;
    logic              fifo_rdreq;
    logic              ram_wr_req;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic              ram_wr_ack;
    logic              ram_data_req;
    logic [DATA_W-1:0] ram_wr_data;
    logic              busy;
    logic              wrap_pulse;
    logic [15:0]       burst_cnt;

    ad_ram_burst_writer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BL),
        .BASE_ADDR(BASE), .REGION_LEN(REGION)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
        .ram_wr_req(ram_wr_req), .ram_wr_addr(ram_wr_addr), .ram_wr_ack(ram_wr_ack),
        .ram_data_req(ram_data_req), .ram_wr_data(ram_wr_data),
        .busy(busy), .wrap_pulse(wrap_pulse), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [15:0] fifo_m[$];
    logic [15:0] exp_q[$];
    logic [15:0] pulled[$];
    logic [ADDR_W-1:0] ack_addrs[$];
    bit          rd_pend;
    logic [15:0] pend_val;
    int          empty_mode;
    bit          tog;
    bit          gap_mode;
    int          gcnt;
    int          ack_delay;
    int          req_age;
    bit          in_burst;
    int          pulls;
    int          bursts;
    int          wraps;
    int          rd_total;
    bit          adv_now;
    bit          done_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        fifo_m.delete(); exp_q.delete(); pulled.delete(); ack_addrs.delete();
        rd_pend = 0; in_burst = 0; pulls = 0; bursts = 0; wraps = 0; rd_total = 0;
        adv_now = 0; done_m = 0; req_age = 0; gcnt = 0;
    endtask

    // One clock: drive inputs after the falling edge, then sample and score
    task automatic cycle();
        bit adv_was;
        bit wrap_exp;
        int done_words;
        @(negedge clk);
        if (rd_pend) begin
            fifo_q  = pend_val;
            rd_pend = 0;
        end else begin
            fifo_q = 16'($urandom);
        end
        tog = ~tog;
        case (empty_mode)
            1:       fifo_empty = (fifo_m.size() == 0) || tog;
            2:       fifo_empty = (fifo_m.size() == 0) || ($urandom_range(2) == 0);
            default: fifo_empty = (fifo_m.size() == 0);
        endcase
        ram_wr_ack = (req_age == ack_delay);
        if (in_burst) begin
            ram_data_req = gap_mode ? (gcnt % 4 == 0) : 1'b1;
            gcnt++;
        end else begin
            ram_data_req = 1'($urandom_range(1));
        end
        #1;
        adv_was    = adv_now;
        adv_now    = 0;
        done_words = (bursts - (adv_was ? 1 : 0)) * BL;
        wrap_exp   = adv_was && ((bursts * BL) % REGION == 0);
        check("rdreq_while_empty", fifo_rdreq && fifo_empty, 0);
        check("burst_cnt", burst_cnt, 16'(bursts - (adv_was ? 1 : 0)));
        check("wr_addr", ram_wr_addr, ADDR_W'(BASE + done_words % REGION));
        check("wrap_pulse", wrap_pulse, wrap_exp);
        if (wrap_exp) wraps++;
        if (in_burst) begin
            check("req_in_burst", ram_wr_req, 0);
            check("busy_in_burst", busy, 1);
            if (exp_q.size() == 0) begin
                check("exp_q_underflow", 0, 1);
            end else begin
                check("wr_data", ram_wr_data, exp_q[0]);
                if (ram_data_req) begin
                    pulled.push_back(ram_wr_data);
                    void'(exp_q.pop_front());
                    pulls++;
                    if (pulls == BL) begin
                        in_burst = 0;
                        bursts++;
                        adv_now = 1;
                    end
                end
            end
        end
        if (done_m) begin
            check("done_busy", busy, 0);
            check("done_rdreq", fifo_rdreq, 0);
            check("done_req", ram_wr_req, 0);
        end
`ifdef RAMWR_ONESHOT_EN
        if (wrap_exp) done_m = 1;
`endif
        if (ram_wr_req) check("busy_in_req", busy, 1);
        if (ram_wr_ack) begin
            check("req_at_ack", ram_wr_req, 1);
            check("words_ready_at_ack", exp_q.size() >= BL, 1);
            ack_addrs.push_back(ram_wr_addr);
            in_burst = 1;
            pulls    = 0;
            gcnt     = 0;
            req_age  = 0;
        end else if (ram_wr_req) begin
            req_age++;
        end else begin
            req_age = 0;
        end
        if (fifo_rdreq && fifo_m.size() > 0) begin
            pend_val = fifo_m.pop_front();
            exp_q.push_back(pend_val);
            rd_pend = 1;
            rd_total++;
        end
    endtask

    task automatic wait_bursts(input int n);
        int t = 0;
        while (bursts < n && t < 3000) begin
            ack_delay = ack_delay;
            cycle();
            t++;
        end
        check("burst_timeout", bursts >= n, 1);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) fifo_m.push_back(16'($urandom));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rdreq"}, fifo_rdreq, 0);
        check({tag, "_req"}, ram_wr_req, 0);
        check({tag, "_addr"}, ram_wr_addr, BASE);
        check({tag, "_data"}, ram_wr_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_wrap"}, wrap_pulse, 0);
        check({tag, "_cnt"}, burst_cnt, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset = 1; enable = 0; fifo_empty = 1; fifo_q = '0;
        ram_wr_ack = 0; ram_data_req = 0;
        empty_mode = 0; tog = 0; gap_mode = 0; ack_delay = 2;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset = 0;

        // Preloaded FIFO 1..8, ack two cycles after request, back-to-back pulls
        for (int i = 1; i <= 8; i++) fifo_m.push_back(16'(i));
        enable = 1;
        wait_bursts(1);
        repeat (2) cycle();
        check("p1_ack_addr", ack_addrs.size() > 0 ? ack_addrs[0] : 'x, 0);
        for (int i = 0; i < 8; i++)
            check("p1_word", pulled.size() > i ? pulled[i] : 'x, i + 1);
        check("p1_burst_cnt", burst_cnt, 1);
        check("p1_next_addr", ram_wr_addr, 8);

        // FIFO empty toggling every cycle during fill; second burst wraps
        empty_mode = 1;
        ack_delay  = $urandom_range(4, 1);
        push_rand(8);
        wait_bursts(2);
        repeat (3) cycle();
        check("p2_ack_addr", ack_addrs.size() > 1 ? ack_addrs[1] : 'x, 8);
        check("p2_wrapped_addr", ram_wr_addr, 0);
        check("p2_wraps", wraps, 1);
        push_rand(8);
        repeat (12) cycle();
`ifdef RAMWR_ONESHOT_EN
        check("p2_done_busy", busy, 0);
        check("p2_done_fifo_untouched", fifo_m.size(), 8);
        enable = 0;
        done_m = 0;
        cycle();
        enable = 1;
`endif

        // Gapped pulls with random FIFO stalls
        gap_mode   = 1;
        empty_mode = 2;
        ack_delay  = $urandom_range(4, 1);
        push_rand(8);
        wait_bursts(4);
        repeat (2) cycle();
        check("p3_ack_addr", ack_addrs.size() > 2 ? ack_addrs[2] : 'x, 0);
        check("p3_wraps", wraps, 2);
        gap_mode   = 0;
        empty_mode = 0;

        // Enable dropped after three words of a fill: burst still completes, then idle
        enable = 0;
        done_m = 0;
        repeat (3) cycle();
        enable = 1;
        t = rd_total;
        push_rand(3);
        begin
            int k = 0;
            while (rd_total < t + 3 && k < 200) begin cycle(); k++; end
        end
        check("p4_three_read", rd_total, t + 3);
        enable = 0;
        repeat (10) cycle();
        check("p4_still_busy", busy, 1);
        check("p4_no_req", ram_wr_req, 0);
        push_rand(5);
        wait_bursts(5);
        repeat (4) cycle();
        check("p4_idle", busy, 0);
        check("p4_burst_cnt", burst_cnt, 5);
        check("p4_addr", ram_wr_addr, 8);

        // Reset asserted mid-burst
        enable = 1;
        push_rand(8);
        t = 0;
        while (!(in_burst && pulls == 3) && t < 2000) begin cycle(); t++; end
        check("p5_reached_burst", in_burst && pulls == 3, 1);
        @(negedge clk);
        ram_data_req = 1;
        reset = 1;
        #1;
        check_reset_values("midburst_reset");
        model_clear();
        @(negedge clk);
        #1;
        check_reset_values("held_reset");
        reset = 0;
        enable = 1;
        ack_delay = 1;
        push_rand(8);
        wait_bursts(1);
        repeat (2) cycle();
        check("p5_ack_addr", ack_addrs.size() > 0 ? ack_addrs[0] : 'x, 0);
        check("p5_burst_cnt", burst_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
